// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : audio_pkg                                                       |
// | Purpose  : Constants and sample type shared by the tone generator and the  |
// |            I2S transmitter.                                                |
// | Contents : SLOT_W   - bclk slots per channel                               |
// |            DATA_W   - audio sample width                                   |
// |            sample_t - signed two's complement audio sample                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package audio_pkg;

  localparam int SLOT_W = 32;
  localparam int DATA_W = 24;

  typedef logic signed [DATA_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/i2s_temporizador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_temporizador                                                |
// | Purpose  : Bit-clock divider and slot counter for the I2S transmitter.     |
// |            bclk is a registered output toggled every CLK_DIV clk cycles;   |
// |            the slot counter advances on every bclk falling transition.     |
// | Ports    : clk           - system clock                                    |
// |            rst_n         - asynchronous active-low reset                   |
// |            i_run         - enable; low forces the reset state              |
// |            o_bclk        - I2S bit clock                                   |
// |            o_bclk_fall   - strobe: bclk goes 1->0 on this clk edge         |
// |            o_slot        - slot being entered on the next bclk fall        |
// |            o_frame_start - strobe: slot wraps to 0 on this clk edge        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2s_temporizador #(
  parameter int CLK_DIV = 9,
  parameter int SLOT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_run,
  output logic                          o_bclk,
  output logic                          o_bclk_fall,
  output logic [$clog2(2*SLOT_W)-1:0]   o_slot,
  output logic                          o_frame_start
);

  localparam int c_NSLOT = 2 * SLOT_W;
  localparam int c_SW    = $clog2(c_NSLOT);
  localparam int c_DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_DW-1:0] c_DIV_END   = c_DW'(CLK_DIV - 1);
  localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(c_NSLOT - 1);

  logic [c_DW-1:0] r_div_cnt;
  logic            r_bclk;
  logic [c_SW-1:0] r_slot;

  logic            w_div_end;
  logic [c_SW-1:0] w_slot_nxt;

  assign w_div_end  = (r_div_cnt == c_DIV_END);
  assign w_slot_nxt = (r_slot == c_SLOT_LAST) ? '0 : r_slot + 1'b1;

  // Slot starts at its last value so the first bclk fall after (re)start
  // lands on slot 0 and is therefore a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_slot    <= c_SLOT_LAST;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_slot    <= c_SLOT_LAST;
    end else begin
      if (w_div_end) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (o_bclk_fall) begin
        r_slot <= w_slot_nxt;
      end
    end
  end

  assign o_bclk        = r_bclk;
  assign o_bclk_fall   = i_run & w_div_end & r_bclk;
  assign o_slot        = w_slot_nxt;
  assign o_frame_start = o_bclk_fall & (r_slot == c_SLOT_LAST);

endmodule
`default_nettype wire

// File: rtl/i2s_transmisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_transmisor                                                  |
// | Purpose  : Stereo I2S serializer. Latches left/right samples at each frame |
// |            start, shifts them MSB first with the standard one-bclk delay   |
// |            after the lrclk edge, and emits the sample-rate enable pulse    |
// |            that paces the tone generator.                                  |
// | Ports    : clk      - system clock                                         |
// |            rst_n    - asynchronous active-low reset                        |
// |            i_run    - serializer enable; low = idle                        |
// |            i_l_data - signed left sample, latched at frame start           |
// |            i_r_data - signed right sample, latched at frame start          |
// |            o_ena    - one-clk pulse at each frame start                    |
// |            o_bclk   - I2S bit clock                                        |
// |            o_lrclk  - I2S word select (0 = left, 1 = right)                |
// |            o_sdata  - I2S serial data, MSB first                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2s_transmisor
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 9,
  parameter int DATA_W  = audio_pkg::DATA_W,
  parameter int SLOT_W  = audio_pkg::SLOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_l_data,
  input  logic [DATA_W-1:0] i_r_data,
  output logic              o_ena,
  output logic              o_bclk,
  output logic              o_lrclk,
  output logic              o_sdata
);

  localparam int c_NSLOT = 2 * SLOT_W;
  localparam int c_SW    = $clog2(c_NSLOT);

  logic              w_bclk_fall;
  logic              w_frame_start;
  logic [c_SW-1:0]   w_slot;

  logic [DATA_W-1:0] r_l_sh;
  logic [DATA_W-1:0] r_r_sh;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_ena;

  logic [DATA_W-1:0] w_word;
  logic              w_sdata_nxt;
  logic              w_lrclk_nxt;
  int                w_k;
  int                w_off;

  i2s_temporizador #(
    .CLK_DIV (CLK_DIV),
    .SLOT_W  (SLOT_W)
  ) u_temporizador (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (i_run),
    .o_bclk        (o_bclk),
    .o_bclk_fall   (w_bclk_fall),
    .o_slot        (w_slot),
    .o_frame_start (w_frame_start)
  );

  // Output values for the slot being entered. Offset 0 carries the one-bclk
  // I2S delay, offsets 1..DATA_W carry the sample MSB first, the rest pad 0.
  // On the frame-start edge the shadows still hold the old frame, but slot 0
  // is always a pad bit so the stale word is never transmitted.
  always_comb begin
    w_k         = int'(w_slot);
    w_word      = (w_k >= SLOT_W) ? r_r_sh : r_l_sh;
    w_off       = (w_k >= SLOT_W) ? (w_k - SLOT_W) : w_k;
    w_sdata_nxt = 1'b0;
    for (int b = 0; b < DATA_W; b++) begin
      if (w_off == (DATA_W - b)) begin
        w_sdata_nxt = w_word[b];
      end
    end
    // lrclk leads the channel data by one slot.
    w_lrclk_nxt = (((w_k + 1) % c_NSLOT) >= SLOT_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l_sh  <= '0;
      r_r_sh  <= '0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
      r_ena   <= 1'b0;
    end else if (!i_run) begin
      r_l_sh  <= '0;
      r_r_sh  <= '0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
      r_ena   <= 1'b0;
    end else begin
      r_ena <= w_frame_start;
      if (w_frame_start) begin
        r_l_sh <= i_l_data;
        r_r_sh <= i_r_data;
      end
      if (w_bclk_fall) begin
        r_sdata <= w_sdata_nxt;
        r_lrclk <= w_lrclk_nxt;
      end
    end
  end

  assign o_ena   = r_ena;
  assign o_lrclk = r_lrclk;
  assign o_sdata = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2s_transmisor                                               |
// | Purpose  : Self-checking bench for i2s_transmisor (CLK_DIV = 2).           |
// |            A codec-style monitor captures sdata/lrclk on bclk rising edges |
// |            and compares each frame against a scoreboard of expected words. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_i2s_transmisor;

  localparam int CLK_DIV = 2;
  localparam int NV      = 6;
  localparam logic [63:0] LR_EXP = {31'b0, 32'hFFFF_FFFF, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [23:0] l_data;
  logic [23:0] r_data;
  logic        ena;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  always #5 clk = ~clk;

  i2s_transmisor #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (run),
    .i_l_data (l_data),
    .i_r_data (r_data),
    .o_ena    (ena),
    .o_bclk   (bclk),
    .o_lrclk  (lrclk),
    .o_sdata  (sdata)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl [NV];
  logic [63:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 0;
  int          viol = 0;

  // Expected 64-slot frame, slot 0 in the MSB.
  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_bclk"},  bclk,  1'b0);
    chk({name, "_lrclk"}, lrclk, 1'b0);
    chk({name, "_sdata"}, sdata, 1'b0);
    chk({name, "_ena"},   ena,   1'b0);
  endtask

  task automatic wait_ena(input int limit);
    bit seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (ena) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL ena_timeout: no ena within %0d clks", limit);
    end
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Release reset (or raise run) and check the first-frame timing clk by clk.
  task automatic first_frame(input bit use_rst);
    @(negedge clk);
    if (use_rst) rst_n = 1'b1;
    else         run   = 1'b1;
    for (int c = 1; c <= 2*CLK_DIV + 1; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("first_bclk_c%0d", c), bclk, (c >= CLK_DIV) && (c < 2*CLK_DIV));
      chk($sformatf("first_ena_c%0d", c),  ena,  (c == 2*CLK_DIV));
      chk($sformatf("first_lrclk_c%0d", c), lrclk, 1'b0);
    end
  endtask

  // Wait until bclk is high inside slot 40 of the next frame.
  task automatic goto_slot40_high();
    bit hi = 0;
    wait_ena(400);
    repeat (40 * 2 * CLK_DIV) @(negedge clk);
    for (int k = 0; k < 10 && !hi; k++) begin
      @(negedge clk);
      if (bclk) hi = 1;
    end
    chk("slot40_bclk_high", bclk, 1'b1);
    chk("slot40_lrclk", lrclk, 1'b1);
    chk("slot40_sdata", sdata, 1'b1);
  endtask

  // Codec-side monitor.
  bit          have_prev = 0;
  bit          collecting = 0;
  int          ena_gap = 0;
  int          slot_i = 0;
  logic        prev_bclk = 1'b0;
  logic        prev_sdata = 1'b0;
  logic        prev_lr = 1'b0;
  logic [63:0] cap_d;
  logic [63:0] cap_lr;
  logic [63:0] exp_w;

  always @(negedge clk) begin
    if (mon_en) begin
      ena_gap++;
      if (ena) begin
        if (have_prev) chk("ena_period", ena_gap, 128 * CLK_DIV);
        have_prev  = 1;
        ena_gap    = 0;
        collecting = 1;
        slot_i     = 0;
      end
      if (bclk && prev_bclk && (sdata !== prev_sdata || lrclk !== prev_lr)) viol++;
      if (bclk && !prev_bclk && collecting) begin
        cap_d[63-slot_i]  = sdata;
        cap_lr[63-slot_i] = lrclk;
        slot_i++;
        if (slot_i == 64) begin
          collecting = 0;
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            chk("frame_sdata", cap_d, exp_w);
            chk("frame_lrclk", cap_lr, LR_EXP);
          end
        end
      end
    end else begin
      have_prev  = 0;
      collecting = 0;
      ena_gap    = 0;
    end
    prev_bclk  = bclk;
    prev_sdata = sdata;
    prev_lr    = lrclk;
  end

  initial begin
    logic [31:0] rnd_l;
    logic [31:0] rnd_r;
    int          n_ena;
    int          n_busy;

    rnd_l = $urandom();
    rnd_r = $urandom();
    tbl[0] = '{l: 24'hA50F3C, r: 24'h5AF0C3, exp: 64'h52879E00_2D786180};
    tbl[1] = '{l: 24'h800000, r: 24'h5AF0C3, exp: 64'h40000000_2D786180};
    tbl[2] = '{l: 24'h7FFFFF, r: 24'h000001, exp: frame_of(24'h7FFFFF, 24'h000001)};
    tbl[3] = '{l: rnd_l[23:0], r: rnd_r[23:0], exp: frame_of(rnd_l[23:0], rnd_r[23:0])};
    tbl[4] = '{l: 24'hFFFFFF, r: 24'h800000, exp: frame_of(24'hFFFFFF, 24'h800000)};
    tbl[5] = '{l: 24'h123456, r: 24'hFFFFFF, exp: frame_of(24'h123456, 24'hFFFFFF)};

    // Reset state and first-frame timing.
    rst_n  = 1'b0;
    run    = 1'b1;
    l_data = tbl[0].l;
    r_data = tbl[0].r;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    exp_q.push_back(tbl[0].exp);
    mon_en = 1;
    first_frame(1'b1);

    // Table vectors: each new sample is driven mid-frame and must appear
    // only in the following frame.
    for (int i = 1; i < NV; i++) begin
      repeat (40) @(negedge clk);
      l_data = tbl[i].l;
      r_data = tbl[i].r;
      exp_q.push_back(tbl[i].exp);
      wait_ena(400);
    end
    wait_drain(600);
    mon_en = 0;

    // run dropped in slot 40.
    goto_slot40_high();
    run = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("run_low");
    n_ena  = 0;
    n_busy = 0;
    repeat (300) begin
      @(negedge clk);
      if (ena) n_ena++;
      if (bclk || lrclk || sdata) n_busy++;
    end
    chk("run_low_ena_count", n_ena, 0);
    chk("run_low_busy_count", n_busy, 0);
    exp_q.push_back(tbl[NV-1].exp);
    mon_en = 1;
    first_frame(1'b0);
    wait_drain(600);
    mon_en = 0;

    // Asynchronous reset while bclk is high.
    goto_slot40_high();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    repeat (3) @(negedge clk);
    chk_idle("reset_hold");
    exp_q.push_back(tbl[NV-1].exp);
    mon_en = 1;
    first_frame(1'b1);
    wait_drain(600);
    mon_en = 0;

    chk("sdata_lrclk_stable_while_bclk_high", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
